// File: rtl/spi_module_pkg.sv
// rtl/spi_module_pkg.sv - shared command encodings and phase lengths for the SPI slave
package spi_module_pkg;

    localparam logic [1:0] SEL_REG0 = 2'b00;
    localparam logic [1:0] SEL_REG1 = 2'b01;
    localparam logic [1:0] SEL_MEM  = 2'b10;

    localparam int WR_BIT   = 6;
    localparam int CMD_BITS = 8;
    localparam int REG_BITS = 32;
    localparam int MEM_BITS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_REG,
        ST_MEM,
        ST_SKIP
    } state_t;

endpackage

// File: rtl/spi_module_sync.sv
// rtl/spi_module_sync.sv - SPI pin synchronizer with sck edge and ncs fall detection
module spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sck_i,
    input  logic mosi_i,
    input  logic ncs_i,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic ncs_fall_o,
    output logic mosi_o,
    output logic ncs_o
);

    logic [SYNC_STAGES-1:0] sck_q, mosi_q, ncs_q;
    logic                   sck_prev_q, ncs_prev_q;

    // ncs chain resets low so a select already held low never looks like a fresh fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q      <= '0;
            mosi_q     <= '0;
            ncs_q      <= '0;
            sck_prev_q <= 1'b0;
            ncs_prev_q <= 1'b0;
        end else begin
            sck_q      <= {sck_q[SYNC_STAGES-2:0], sck_i};
            mosi_q     <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
            ncs_q      <= {ncs_q[SYNC_STAGES-2:0], ncs_i};
            sck_prev_q <= sck_q[SYNC_STAGES-1];
            ncs_prev_q <= ncs_q[SYNC_STAGES-1];
        end
    end

    assign sck_rise_o = sck_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign sck_fall_o = ~sck_q[SYNC_STAGES-1] & sck_prev_q;
    assign ncs_fall_o = ~ncs_q[SYNC_STAGES-1] & ncs_prev_q;
    assign mosi_o     = mosi_q[SYNC_STAGES-1];
    assign ncs_o      = ncs_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_module.sv
// rtl/spi_module.sv - SPI mode-0 slave with command decode, two control registers and memory streaming
module spi_module
    import spi_module_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MEM_AW      = 12,
    parameter int MEM_DW      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              mosi,
    input  logic              ncs,
    output logic              miso,
    output logic [7:0]        q_c,
    output logic [31:0]       q_0,
    output logic [31:0]       q_1,
    input  logic [MEM_DW-1:0] mem_data,
    output logic [MEM_AW-1:0] mem_addr
);

    localparam logic [5:0] CMD_LAST   = 6'(CMD_BITS - 1);
    localparam logic [5:0] DATA_FIRST = 6'(CMD_BITS);
    localparam logic [5:0] REG_LAST   = 6'(CMD_BITS + REG_BITS - 1);
    localparam int         MCW        = $clog2(MEM_BITS);

    logic sck_rise, sck_fall, ncs_fall, mosi_s, ncs_s;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .sck_i      (sck),
        .mosi_i     (mosi),
        .ncs_i      (ncs),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .ncs_fall_o (ncs_fall),
        .mosi_o     (mosi_s),
        .ncs_o      (ncs_s)
    );

    state_t            state_q;
    logic [5:0]        bit_cnt_q;
    logic [6:0]        cmd_q;
    logic [30:0]       rx_q;
    logic [31:0]       out_q;
    logic [1:0]        sel_q;
    logic              wr_q;
    logic [MCW-1:0]    mem_cnt_q;
    logic [7:0]        q_c_q;
    logic [31:0]       q_0_q, q_1_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic              miso_q;

    logic [7:0]  cmd_d;
    logic [31:0] rx_d;

    assign cmd_d = {cmd_q, mosi_s};
    assign rx_d  = {rx_q, mosi_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            cmd_q      <= '0;
            rx_q       <= '0;
            out_q      <= '0;
            sel_q      <= '0;
            wr_q       <= 1'b0;
            mem_cnt_q  <= '0;
            q_c_q      <= '0;
            q_0_q      <= '0;
            q_1_q      <= '0;
            mem_addr_q <= '0;
            miso_q     <= 1'b0;
        end else if (ncs_s) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            out_q     <= '0;
            miso_q    <= 1'b0;
        end else begin
            miso_q <= (state_q == ST_IDLE) ? 1'b0 : out_q[31];
            case (state_q)
                ST_IDLE: begin
                    if (ncs_fall) begin
                        state_q   <= ST_CMD;
                        bit_cnt_q <= '0;
                        out_q     <= {q_c_q, 24'h0};
                    end
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        cmd_q     <= cmd_d[6:0];
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == CMD_LAST) begin
                            q_c_q     <= cmd_d;
                            sel_q     <= cmd_d[1:0];
                            wr_q      <= cmd_d[WR_BIT];
                            mem_cnt_q <= '0;
                            case (cmd_d[1:0])
                                SEL_REG0, SEL_REG1: state_q <= ST_REG;
                                SEL_MEM: begin
                                    state_q    <= ST_MEM;
                                    mem_addr_q <= '0;
                                end
                                default: state_q <= ST_SKIP;
                            endcase
                        end
                    end else if (sck_fall) begin
                        out_q <= out_q << 1;
                    end
                end
                ST_REG: begin
                    // counter parks one past the last data bit, blocking further writes
                    if (sck_rise && bit_cnt_q <= REG_LAST) begin
                        rx_q      <= rx_d[30:0];
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == REG_LAST && wr_q) begin
                            if (sel_q == SEL_REG1) q_1_q <= rx_d;
                            else                   q_0_q <= rx_d;
                        end
                    end else if (sck_fall) begin
                        if (bit_cnt_q == DATA_FIRST)
                            out_q <= (sel_q == SEL_REG1) ? q_1_q : q_0_q;
                        else
                            out_q <= out_q << 1;
                    end
                end
                ST_MEM: begin
                    if (sck_fall) begin
                        mem_cnt_q <= mem_cnt_q + 1'b1;
                        if (mem_cnt_q == '0) begin
                            out_q      <= {mem_data, {(32-MEM_DW){1'b0}}};
                            mem_addr_q <= mem_addr_q + 1'b1;
                        end else begin
                            out_q <= out_q << 1;
                        end
                    end
                end
                ST_SKIP: out_q <= '0;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign miso     = miso_q;
    assign q_c      = q_c_q;
    assign q_0      = q_0_q;
    assign q_1      = q_1_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_spi_module.sv
// tb/tb_spi_module.sv - randomized self-checking bench for the SPI slave against a transaction-level model
module tb_spi_module;

    localparam int HALF = 80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic        ncs = 1'b1;
    logic        miso;
    logic [7:0]  q_c;
    logic [31:0] q_0, q_1;
    logic [15:0] mem_data;
    logic [11:0] mem_addr;

    logic [15:0] mem_arr [0:4095];
    logic        use_e = 1'b0;
    logic        rx_bits [0:1023];

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] m_r0, m_r1;
    logic [7:0]  m_qc;

    always #5 clk = ~clk;

    assign mem_data = use_e ? {4'hE, mem_addr} : mem_arr[mem_addr];

    spi_module #(.SYNC_STAGES(2), .MEM_AW(12), .MEM_DW(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .sck      (sck),
        .mosi     (mosi),
        .ncs      (ncs),
        .miso     (miso),
        .q_c      (q_c),
        .q_0      (q_0),
        .q_1      (q_1),
        .mem_data (mem_data),
        .mem_addr (mem_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rx_word(input int start, input int n);
        logic [31:0] w = '0;
        for (int j = 0; j < n; j++) w = {w[30:0], rx_bits[start + j]};
        return w;
    endfunction

    // master side: one ncs-low window carrying the command and ndata data bits
    task automatic spi_xfer(input logic [7:0] cmd, input logic [31:0] wdata, input int ndata);
        int total = 8 + ndata;
        ncs = 1'b0;
        for (int i = 0; i < total; i++) begin
            if (i < 8)           mosi = cmd[7 - i];
            else if (i - 8 < 32) mosi = wdata[31 - (i - 8)];
            else                 mosi = 1'($urandom);
            #HALF;
            rx_bits[i] = miso;
            sck = 1'b1;
            #HALF;
            sck = 1'b0;
        end
        #HALF;
        ncs = 1'b1;
        #(2 * HALF);
    endtask

    task automatic do_reg(input logic [7:0] cmd, input logic [31:0] wdata, input int ndata);
        logic [7:0]  exp_st = m_qc;
        logic [31:0] exp_rd;
        case (cmd[1:0])
            2'b00:   exp_rd = m_r0;
            2'b01:   exp_rd = m_r1;
            default: exp_rd = '0;
        endcase
        spi_xfer(cmd, wdata, ndata);
        m_qc = cmd;
        if (ndata >= 32 && cmd[6]) begin
            if (cmd[1:0] == 2'b00) m_r0 = wdata;
            if (cmd[1:0] == 2'b01) m_r1 = wdata;
        end
        check("status", {24'h0, rx_word(0, 8)}, {24'h0, exp_st});
        if (ndata >= 32) check("read_data", rx_word(8, 32), exp_rd);
        if (ndata > 32) check("tail_zero", rx_word(40, ndata - 32), 32'h0);
        check("q_c", {24'h0, q_c}, {24'h0, m_qc});
        check("q_0", q_0, m_r0);
        check("q_1", q_1, m_r1);
    endtask

    task automatic do_mem(input logic [7:0] cmd, input int nwords);
        logic [7:0]  exp_st = m_qc;
        logic [15:0] exp_w;
        spi_xfer(cmd, $urandom, 16 * nwords);
        m_qc = cmd;
        check("mem_status", {24'h0, rx_word(0, 8)}, {24'h0, exp_st});
        for (int k = 0; k < nwords; k++) begin
            exp_w = use_e ? {4'hE, 12'(k)} : mem_arr[k % 4096];
            check($sformatf("mem_word%0d", k), rx_word(8 + 16 * k, 16), {16'h0, exp_w});
        end
        check("mem_addr", {20'h0, mem_addr}, 32'((nwords + 1) % 4096));
        check("mem_q_c", {24'h0, q_c}, {24'h0, m_qc});
        check("mem_q_0", q_0, m_r0);
        check("mem_q_1", q_1, m_r1);
    endtask

    initial begin
        logic [7:0] rc;
        for (int a = 0; a < 4096; a++) mem_arr[a] = 16'($urandom);
        m_r0 = '0;
        m_r1 = '0;
        m_qc = '0;

        #20;
        check("rst_q_c", {24'h0, q_c}, 32'h0);
        check("rst_q_0", q_0, 32'h0);
        check("rst_q_1", q_1, 32'h0);
        check("rst_mem_addr", {20'h0, mem_addr}, 32'h0);
        check("rst_miso", {31'h0, miso}, 32'h0);
        rst = 1'b0;
        #20;

        do_reg(8'hA0, 32'h24AF55AA, 32);
        do_reg(8'h55, 32'h01234567, 32);
        do_reg(8'hA0, 32'h01010101, 32);
        do_reg(8'h51, 32'h01010202, 32);

        use_e = 1'b1;
        do_mem(8'h02, 16);
        use_e = 1'b0;

        do_reg(8'h55, $urandom, 20);
        do_reg(8'h41, $urandom, 40);
        do_reg(8'h43, $urandom, 36);
        do_mem(8'h42, 3);

        for (int it = 0; it < 10; it++) begin
            rc = 8'($urandom);
            if (rc[1:0] == 2'b10) do_mem(rc, int'($urandom_range(1, 4)));
            else                  do_reg(rc, $urandom, ($urandom_range(0, 1) != 0) ? 32 : 38);
        end

        // reset in the middle of a memory stream
        ncs = 1'b0;
        for (int i = 0; i < 20; i++) begin
            mosi = (i < 8) ? ((8'h02 >> (7 - i)) & 1) != 0 : 1'b0;
            #HALF;
            sck = 1'b1;
            #HALF;
            sck = 1'b0;
        end
        #40;
        rst = 1'b1;
        #20;
        check("mid_rst_q_c", {24'h0, q_c}, 32'h0);
        check("mid_rst_q_0", q_0, 32'h0);
        check("mid_rst_q_1", q_1, 32'h0);
        check("mid_rst_mem_addr", {20'h0, mem_addr}, 32'h0);
        check("mid_rst_miso", {31'h0, miso}, 32'h0);
        rst = 1'b0;
        m_r0 = '0;
        m_r1 = '0;
        m_qc = '0;
        for (int i = 0; i < 4; i++) begin
            #HALF;
            sck = 1'b1;
            #HALF;
            sck = 1'b0;
        end
        check("post_rst_idle_miso", {31'h0, miso}, 32'h0);
        ncs = 1'b1;
        #(2 * HALF);
        do_reg(8'h40, $urandom, 32);
        do_reg(8'h01, $urandom, 32);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/spi_module.md
Name: spi_module

Overview:
- SPI slave (mode 0, MSB first) bridging an external SPI master into the system clock domain.
- Each transaction is an 8-bit command byte followed by a data phase.
- The data phase either reads/writes one of two 32-bit control registers, or streams 16-bit words from an external memory port at auto-incrementing addresses.
- Sits between the board SPI pins and core logic, which consumes q_0/q_1/q_c and supplies memory data.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for sck/mosi/ncs.
- MEM_AW, 12, memory address width.
- MEM_DW, 16, memory word width.

Ports:
- clk  in  1  system clock; all logic runs on it.
- rst  in  1  asynchronous active-high reset.
- sck  in  1  SPI clock, asynchronous to clk.
- mosi  in  1  SPI master-out data.
- ncs  in  1  SPI chip select, active low.
- miso  out  1  SPI slave-out data.
- q_c  out  8  last complete command byte received.
- q_0  out  32  control register 0.
- q_1  out  32  control register 1.
- mem_data  in  16  memory read data for mem_addr.
- mem_addr  out  12  memory read address.

Behaviour:
- Reset: q_c, q_0, q_1, mem_addr = 0; miso = 0; bit counter = 0; shift registers = 0. Reset is asynchronous and active-high.
- Synchronization: sck, mosi and ncs each pass through SYNC_STAGES flops. Rising and falling sck edges are detected in the clk domain.
- Timing requirement: sck high and low times must each be at least 4 clk periods.
- SPI mode 0: mosi is sampled on the sck rising edge; miso is updated on the sck falling edge. The first miso bit is valid as soon as ncs falls.
- ncs high: bit counter clears; the transaction aborts with no register write; miso = 0.
- Command phase (bits 0-7):
  - mosi is shifted into the command register.
  - miso shifts out the status byte, which is the q_c value at transaction start (the previous command).
- Command decode, on the 8th rising edge:
  - q_c is updated to the new command byte.
  - sel = cmd[1:0]: 00 = REG0, 01 = REG1, 10 = MEM, 11 = reserved.
  - wr = cmd[6].
- Register access (sel 00/01), bits 8-39:
  - The output shifter is loaded with the selected register value at the 8th falling edge and shifted out MSB first.
  - mosi is shifted into a 32-bit receive register.
  - On the 40th rising edge, if wr = 1, the selected register is loaded with the received word; otherwise it is unchanged.
  - Bits beyond 40 are ignored: miso = 0 and no further writes occur.
- Memory stream (sel 10):
  - mem_addr is set to 0 at the 8th rising edge.
  - At the 8th falling edge, and at every 16th falling edge after it, the shifter is loaded with mem_data and mem_addr is incremented.
  - mem_addr wraps from 4095 to 0.
  - mem_data must be valid 2 clk after mem_addr changes.
  - Streaming continues until ncs rises. mosi is ignored and wr has no effect.
- Reserved select (11): miso = 0 throughout the data phase; no register writes.
- A fresh ncs fall always restarts at the command phase.
- rst asserted mid-transaction: immediate return to reset state; the transaction restarts only after ncs next falls.

Decomposition:
- Shared package: command select encodings (SEL_REG0, SEL_REG1, SEL_MEM), write bit index (6), phase bit counts (8, 32, 16).
- One sub-module, spi_sync: synchronizer plus sck rise/fall and ncs fall edge detect.
- Shift logic, command decode and registers live in the top level.

Test Plan:
- After reset, send cmd 0xA0 with data 0x24AF55AA -> status 0x00, read data 0x00000000, q_0 stays 0, q_c = 0xA0.
- Send cmd 0x55 with data 0x01234567 -> status 0xA0, read data 0x00000000, q_1 = 0x01234567, q_c = 0x55.
- Send cmd 0xA0 with data 0x01010101 -> status 0x55, read data 0x00000000, q_0 unchanged at 0.
- Send cmd 0x51 with data 0x01010202 -> status 0xA0, read data 0x01234567, q_1 = 0x01010202.
- Send cmd 0x02, then 16 16-bit words, with mem_data = {4'hE, mem_addr} -> words 0xE000 through 0xE00F in order, status 0x51.
- Assert ncs high after 20 data bits of cmd 0x55 -> q_1 unchanged; next transaction starts with a clean command phase. Assert rst mid-stream -> all outputs 0.
